// File: rtl/gyro_spi_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : gyro_spi_reader
//  Purpose  : SPI master (mode 3) that periodically burst-reads the six
//             angular-rate bytes of the IMU. Each sample is published as three
//             16-bit words with a one-cycle valid strobe.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_100mhz  in   system clock
//    rst_n_in    in   asynchronous active-low reset
//    en_in       in   allow sample ticks to start transactions
//    miso_in     in   SPI data from the IMU
//    sclk_out    out  SPI clock, idles high
//    mosi_out    out  SPI data to the IMU
//    cs_n_out    out  chip select, active low
//    gx/gy/gz    out  X/Y/Z rate words, {H, L}
//    valid_out   out  one-cycle pulse when gx/gy/gz update
//    overrun_out out  sticky: a tick arrived while a transaction was running
// ============================================================================
module gyro_spi_reader #(
  parameter int         CLK_DIV       = 50,
  parameter int         SAMPLE_PERIOD = 100000,
  parameter logic [7:0] START_ADDR    = 8'h43
) (
  input  logic        clk_100mhz,
  input  logic        rst_n_in,
  input  logic        en_in,
  input  logic        miso_in,
  output logic        sclk_out,
  output logic        mosi_out,
  output logic        cs_n_out,
  output logic [15:0] gx,
  output logic [15:0] gy,
  output logic [15:0] gz,
  output logic        valid_out,
  output logic        overrun_out
);

  localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [5:0]          c_LAST_BIT  = 6'd55;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_CS_HOLD  = 3'd3,
    S_PUBLISH  = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_DIV_W-1:0]   r_div, w_div_nxt;
  logic [5:0]           r_bit, w_bit_nxt;
  logic                 r_phase, w_phase_nxt;   // 0 = SCLK low half, 1 = high half
  logic [c_TICK_W-1:0]  r_tick_cnt;
  logic [55:0]          r_tx;
  logic [47:0]          r_rx;                   // address-phase bits fall off the top
  logic                 r_sclk, r_mosi, r_cs_n, r_valid, r_overrun;
  logic [15:0]          r_gx, r_gy, r_gz;

  logic w_tick, w_div_end, w_start, w_enter_low, w_enter_high, w_sample;
  logic w_end_shift, w_done;

  assign w_tick    = (r_tick_cnt == c_TICK_LAST);
  assign w_div_end = (r_div == c_DIV_LAST);
  // Rising-edge cycle: first cycle of a high half.
  assign w_sample  = (r_state == S_SHIFT) && r_phase && (r_div == '0);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic and transition strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div + c_DIV_W'(1);
    w_bit_nxt    = r_bit;
    w_phase_nxt  = r_phase;
    w_start      = 1'b0;
    w_enter_low  = 1'b0;
    w_enter_high = 1'b0;
    w_end_shift  = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (w_tick && en_in) begin
          w_state_nxt = S_CS_SETUP;
          w_start     = 1'b1;
        end
      end
      S_CS_SETUP: begin
        if (w_div_end) begin
          w_state_nxt = S_SHIFT;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_enter_low = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_div_end) begin
          w_div_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt  = 1'b1;
            w_enter_high = 1'b1;
          end else if (r_bit == c_LAST_BIT) begin
            w_state_nxt = S_CS_HOLD;
            w_end_shift = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 6'd1;
            w_phase_nxt = 1'b0;
            w_enter_low = 1'b1;
          end
        end
      end
      S_CS_HOLD: begin
        if (w_div_end) begin
          w_state_nxt = S_PUBLISH;
          w_div_nxt   = '0;
          w_done      = 1'b1;
        end
      end
      S_PUBLISH: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: tick counter, shift registers and registered pin/output drive.
  // Pins are updated on the same edge the FSM enters the corresponding phase,
  // so each phase lasts exactly CLK_DIV cycles on the wire.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tick_cnt <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_sclk     <= 1'b1;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_gx       <= '0;
      r_gy       <= '0;
      r_gz       <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_TICK_W'(1);
      r_valid    <= w_done;

      if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;

      if (w_start) begin
        r_tx   <= {1'b1, START_ADDR[6:0], 48'b0};
        r_cs_n <= 1'b0;
      end

      if (w_enter_low) begin
        r_sclk <= 1'b0;
        r_mosi <= r_tx[55];
        r_tx   <= {r_tx[54:0], 1'b0};
      end

      if (w_enter_high) r_sclk <= 1'b1;
      if (w_sample)     r_rx   <= {r_rx[46:0], miso_in};
      if (w_end_shift)  r_mosi <= 1'b0;

      // Words are loaded together with the valid strobe so consumers see a
      // coherent sample in the pulse cycle.
      if (w_done) begin
        r_cs_n <= 1'b1;
        r_gx   <= r_rx[47:32];
        r_gy   <= r_rx[31:16];
        r_gz   <= r_rx[15:0];
      end
    end
  end

  assign sclk_out    = r_sclk;
  assign mosi_out    = r_mosi;
  assign cs_n_out    = r_cs_n;
  assign gx          = r_gx;
  assign gy          = r_gy;
  assign gz          = r_gz;
  assign valid_out   = r_valid;
  assign overrun_out = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_gyro_spi_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_gyro_spi_reader
//  Purpose  : Self-checking bench for gyro_spi_reader with an SPI slave model
//             and a queue-based scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gyro_spi_reader;

  localparam int DIV    = 4;
  localparam int PERIOD = 300;                 // shorter than a transaction
  localparam int LAT    = 457;                 // 4 + 112*4 + 4 + 1

  logic        clk_100mhz = 1'b0;
  logic        rst_n_in   = 1'b1;
  logic        en_in      = 1'b0;
  logic        miso_in    = 1'b0;
  logic        sclk_out, mosi_out, cs_n_out, valid_out, overrun_out;
  logic [15:0] gx, gy, gz;

  gyro_spi_reader #(
    .CLK_DIV       (DIV),
    .SAMPLE_PERIOD (PERIOD),
    .START_ADDR    (8'h43)
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n_in    (rst_n_in),
    .en_in       (en_in),
    .miso_in     (miso_in),
    .sclk_out    (sclk_out),
    .mosi_out    (mosi_out),
    .cs_n_out    (cs_n_out),
    .gx          (gx),
    .gy          (gy),
    .gz          (gz),
    .valid_out   (valid_out),
    .overrun_out (overrun_out)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Directed vectors: bytes returned by the slave and hand-computed words.
  logic [47:0] vec_data [5] = '{48'h1234_FEDC_8001, 48'h7FFF_0000_FFFF,
                                48'hA55A_0180_C33C, 48'hDEAD_BEEF_0011,
                                48'h0001_8000_55AA};
  logic [15:0] vec_gx [5] = '{16'h1234, 16'h7FFF, 16'hA55A, 16'hDEAD, 16'h0001};
  logic [15:0] vec_gy [5] = '{16'hFEDC, 16'h0000, 16'h0180, 16'hBEEF, 16'h8000};
  logic [15:0] vec_gz [5] = '{16'h8001, 16'hFFFF, 16'hC33C, 16'h0011, 16'h55AA};
  int vec_sel   = 0;
  bit abort_txn = 1'b0;

  int unsigned cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Sample-tick model
  int tb_cnt;
  always @(posedge clk_100mhz or negedge rst_n_in)
    if (!rst_n_in) tb_cnt <= 0;
    else           tb_cnt <= (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;

  // Scoreboard producer
  typedef struct {
    logic [15:0] gx, gy, gz;
    int unsigned at;
  } exp_t;
  exp_t   sb[$];
  exp_t   e_new, e_got;
  longint busy_until = -1;
  bit     exp_ovr    = 1'b0;

  always @(negedge clk_100mhz) begin
    if (!rst_n_in) begin
      sb.delete();
      busy_until = -1;
      exp_ovr    = 1'b0;
    end else if (tb_cnt == PERIOD - 1) begin
      if (longint'(cyc) <= busy_until) begin
        exp_ovr = 1'b1;
      end else if (en_in) begin
        e_new.gx = vec_gx[vec_sel];
        e_new.gy = vec_gy[vec_sel];
        e_new.gz = vec_gz[vec_sel];
        e_new.at = cyc + LAT;
        sb.push_back(e_new);
        busy_until = longint'(cyc) + LAT;
      end
    end
  end

  // Scoreboard monitor
  int valid_cnt = 0;
  always @(negedge clk_100mhz) begin
    if (rst_n_in && valid_out) begin
      valid_cnt++;
      chk("valid_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e_got = sb.pop_front();
        chk("gx", gx, e_got.gx);
        chk("gy", gy, e_got.gy);
        chk("gz", gz, e_got.gz);
        chk("valid_latency_cycle", cyc, e_got.at);
        chk("overrun_at_valid", overrun_out, exp_ovr);
      end
    end
  end

  // SPI slave model (mode 3: drive on falling edge, master samples on rising)
  logic [55:0] sl_sh    = '0;
  logic [55:0] mosi_cap = '0;
  int sl_falls    = 0;
  int cs_fall_cnt = 0;
  bit sl_active   = 1'b0;

  always @(negedge cs_n_out) begin
    if (rst_n_in) begin
      sl_sh     = {8'hA5, vec_data[vec_sel]};
      sl_falls  = 0;
      mosi_cap  = '0;
      sl_active = 1'b1;
      cs_fall_cnt++;
    end
  end

  always @(negedge sclk_out) begin
    if (!cs_n_out) begin
      miso_in = sl_sh[55];
      sl_sh   = {sl_sh[54:0], 1'b0};
      sl_falls++;
    end
  end

  always @(posedge sclk_out)
    if (!cs_n_out) mosi_cap = {mosi_cap[54:0], mosi_out};

  always @(posedge cs_n_out) begin
    if (sl_active && !abort_txn) begin
      chk("sclk_fall_count", sl_falls, 56);
      chk("mosi_cmd_byte", mosi_cap[55:48], 8'hC3);
      chk("mosi_pad_zero", mosi_cap[47:0], 48'h0);
    end
    sl_active = 1'b0;
  end

  // SCLK phase / MOSI edge checker
  logic prev_sclk = 1'b1, prev_cs = 1'b1, prev_mosi = 1'b0;
  int   run_len   = 0;
  int   phase_err = 0;
  always @(negedge clk_100mhz) begin
    if (rst_n_in) begin
      if (!cs_n_out && prev_cs) begin
        run_len   = 1;
        phase_err = 0;
      end else if (!cs_n_out) begin
        if (sclk_out != prev_sclk) begin
          if (run_len != DIV) phase_err++;
          run_len = 1;
        end else begin
          run_len++;
        end
        if ((mosi_out != prev_mosi) && !(prev_sclk && !sclk_out)) phase_err++;
      end else if (!prev_cs && !abort_txn) begin
        // last high half plus CS hold, both with SCLK high
        if (run_len != 2 * DIV) phase_err++;
        chk("sclk_phase_timing", phase_err, 0);
      end
    end
    prev_sclk = sclk_out;
    prev_cs   = cs_n_out;
    prev_mosi = mosi_out;
  end

  // Idle activity watch
  bit idle_watch    = 1'b0;
  int idle_activity = 0;
  always @(negedge clk_100mhz)
    if (idle_watch && (!cs_n_out || !sclk_out || valid_out)) idle_activity++;

  task automatic wait_valids(input int n, input int budget);
    for (int i = 0; i < budget && valid_cnt < n; i++) @(posedge clk_100mhz);
    #1;
    chk($sformatf("wait_valid_%0d", n), valid_cnt >= n, 1);
  endtask

  task automatic wait_cs(input int n, input int budget);
    for (int i = 0; i < budget && cs_fall_cnt < n; i++) @(posedge clk_100mhz);
    #1;
    chk($sformatf("wait_cs_%0d", n), cs_fall_cnt >= n, 1);
  endtask

  task automatic wait_falls(input int n, input int budget);
    for (int i = 0; i < budget && sl_falls < n; i++) @(posedge clk_100mhz);
    #1;
    chk($sformatf("wait_sclk_falls_%0d", n), sl_falls >= n, 1);
  endtask

  initial begin
    #1 rst_n_in = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    chk("reset_cs_n", cs_n_out, 1);
    chk("reset_sclk", sclk_out, 1);
    chk("reset_mosi", mosi_out, 0);
    chk("reset_gx", gx, 0);
    chk("reset_gy", gy, 0);
    chk("reset_gz", gz, 0);
    chk("reset_valid", valid_out, 0);
    chk("reset_overrun", overrun_out, 0);
    rst_n_in   = 1'b1;

    // Three periods idle with en_in low
    idle_watch = 1'b1;
    repeat (3 * PERIOD) @(posedge clk_100mhz);
    #1;
    idle_watch = 1'b0;
    chk("idle_activity", idle_activity, 0);
    chk("idle_valid_cnt", valid_cnt, 0);
    chk("idle_gx", gx, 0);
    chk("idle_overrun", overrun_out, 0);

    // Back-to-back sampling; every second tick lands mid-transaction
    vec_sel = 0;
    en_in   = 1'b1;
    wait_valids(1, 2 * PERIOD + LAT + 10);
    vec_sel = 1;
    wait_valids(2, 2 * PERIOD + LAT + 10);
    vec_sel = 2;
    wait_cs(3, 2 * PERIOD);
    repeat (100) @(posedge clk_100mhz);
    #1;
    en_in = 1'b0;                       // dropped during SHIFT
    wait_valids(3, LAT + 10);
    repeat (4 * PERIOD) @(posedge clk_100mhz);
    #1;
    chk("no_restart_cs", cs_fall_cnt, 3);
    chk("no_restart_valid", valid_cnt, 3);
    chk("hold_gx", gx, 16'hA55A);
    chk("hold_gy", gy, 16'h0180);
    chk("hold_gz", gz, 16'hC33C);
    chk("overrun_sticky", overrun_out, 1);

    // Reset in the middle of a transaction
    abort_txn = 1'b1;
    vec_sel   = 3;
    en_in     = 1'b1;
    wait_cs(4, 2 * PERIOD);
    wait_falls(20, 300);
    @(posedge clk_100mhz);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("abort_cs_n_async", cs_n_out, 1);
    chk("abort_sclk_async", sclk_out, 1);
    chk("abort_mosi_async", mosi_out, 0);
    repeat (3) @(posedge clk_100mhz);
    #1;
    chk("abort_no_valid", valid_cnt, 3);
    chk("abort_gx_cleared", gx, 0);
    chk("abort_overrun_cleared", overrun_out, 0);
    vec_sel   = 4;
    abort_txn = 1'b0;
    rst_n_in  = 1'b1;
    wait_valids(4, 2 * PERIOD + LAT + 10);
    en_in = 1'b0;
    repeat (PERIOD) @(posedge clk_100mhz);
    #1;
    chk("final_valid_cnt", valid_cnt, 4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
